// File: rtl/pe_param_pkg.sv
// Shared types and constants for the parameterised row-stationary PE:
// FSM state encoding, tile-configuration field layout and its decoder.
package pe_param_pkg;

    localparam int CONFIG_SIZE    = 13;
    localparam int CFG_Q_LSB      = 0;
    localparam int CFG_Q_W        = 2;
    localparam int CFG_F_LSB      = 2;
    localparam int CFG_F_W        = 5;
    localparam int CFG_P_LSB      = 7;
    localparam int CFG_P_W        = 2;
    localparam int CFG_MODE_BIT   = 9;
    localparam int CFG_RS_LSB     = 10;
    localparam int CFG_RS_W       = 2;
    localparam int CFG_STRIDE_BIT = 12;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READ_FILTER = 3'd1,
        READ_IFMAP  = 3'd2,
        READ_IPSUM  = 3'd3,
        CONV        = 3'd4,
        WRITE_OPSUM = 3'd5
    } pe_state_e;

    typedef struct packed {
        logic [2:0]         p;
        logic [2:0]         q;
        logic [2:0]         rs;
        logic [1:0]         stride;
        logic [CFG_F_W-1:0] f;
        logic               mode;
    } pe_cfg_t;

    // Fields are stored minus one; a column count of zero means one column.
    function automatic pe_cfg_t decode_cfg(input logic [CONFIG_SIZE-1:0] c);
        pe_cfg_t d;
        d.q      = {1'b0, c[CFG_Q_LSB +: CFG_Q_W]} + 3'd1;
        d.p      = {1'b0, c[CFG_P_LSB +: CFG_P_W]} + 3'd1;
        d.rs     = {1'b0, c[CFG_RS_LSB +: CFG_RS_W]} + 3'd1;
        d.stride = {1'b0, c[CFG_STRIDE_BIT]} + 2'd1;
        d.mode   = c[CFG_MODE_BIT];
        d.f      = (c[CFG_F_LSB +: CFG_F_W] == 5'd0) ? 5'd1 : c[CFG_F_LSB +: CFG_F_W];
        return d;
    endfunction

endpackage

// File: rtl/pe_param_if.sv
// Streaming ports of the PE: filter/ifmap/ipsum inputs and the opsum output,
// each a valid/ready channel. The PE side uses the slave modport.
interface pe_param_if #(
    parameter int DATA_BITS = 32
);
    logic [DATA_BITS-1:0] ifmap;
    logic                 ifmap_valid;
    logic                 ifmap_ready;
    logic [DATA_BITS-1:0] filter;
    logic                 filter_valid;
    logic                 filter_ready;
    logic [DATA_BITS-1:0] ipsum;
    logic                 ipsum_valid;
    logic                 ipsum_ready;
    logic [DATA_BITS-1:0] opsum;
    logic                 opsum_valid;
    logic                 opsum_ready;

    modport master (
        output ifmap, ifmap_valid, filter, filter_valid, ipsum, ipsum_valid, opsum_ready,
        input  ifmap_ready, filter_ready, ipsum_ready, opsum, opsum_valid
    );

    modport slave (
        input  ifmap, ifmap_valid, filter, filter_valid, ipsum, ipsum_valid, opsum_ready,
        output ifmap_ready, filter_ready, ipsum_ready, opsum, opsum_valid
    );
endinterface

// File: rtl/pe_mac.sv
// Signed element multiply-accumulate: psum_next = psum_cur + filt * ifmap,
// product sign-extended and the sum wrapping at PSUM_BITS.
module pe_mac #(
    parameter int ELEM_BITS = 8,
    parameter int PSUM_BITS = 32
) (
    input  logic [ELEM_BITS-1:0] filt_elem,
    input  logic [ELEM_BITS-1:0] ifmap_elem,
    input  logic [PSUM_BITS-1:0] psum_cur,
    output logic [PSUM_BITS-1:0] psum_next
);

    logic signed [2*ELEM_BITS-1:0] prod_s;
    logic signed [PSUM_BITS-1:0]   prod_ext_s;

    // Full-precision signed product, widened with its sign before accumulation.
    always_comb begin
        prod_s     = $signed(filt_elem) * $signed(ifmap_elem);
        prod_ext_s = PSUM_BITS'(prod_s);
        psum_next  = psum_cur + $unsigned(prod_ext_s);
    end

endmodule

// File: rtl/pe_param.sv
// Parameterised processing element: loads filter, ifmap and ipsum tiles into
// scratchpads, runs p*q*rs MACs per column and streams p partial sums out.
module pe_param #(
    parameter int DATA_BITS       = 32,
    parameter int ELEM_BITS       = 8,
    parameter int PSUM_BITS       = 32,
    parameter int IFMAP_SPAD_LEN  = 16,
    parameter int FILTER_SPAD_LEN = 64,
    parameter int PSUM_SPAD_LEN   = 4,
    parameter int CONFIG_SIZE     = pe_param_pkg::CONFIG_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   PE_en,
    input  logic [CONFIG_SIZE-1:0] i_config,
    pe_param_if.slave              bus,
    output logic                   done,
    output logic                   cfg_err
);
    import pe_param_pkg::*;

    localparam int LANES = DATA_BITS / ELEM_BITS;
    localparam int CNT_W = ($clog2(FILTER_SPAD_LEN + 1) > 7) ? $clog2(FILTER_SPAD_LEN + 1) : 7;
    localparam int FI_IW = (FILTER_SPAD_LEN > 1) ? $clog2(FILTER_SPAD_LEN) : 1;
    localparam int IF_IW = (IFMAP_SPAD_LEN > 1) ? $clog2(IFMAP_SPAD_LEN) : 1;
    localparam int PS_IW = (PSUM_SPAD_LEN > 1) ? $clog2(PSUM_SPAD_LEN) : 1;
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [ELEM_BITS-1:0] SIGN_FLIP = ELEM_BITS'(1) << (ELEM_BITS - 1);

    pe_state_e state_r, state_s;
    pe_cfg_t   cfg_s;
    logic [CNT_W-1:0] qrs_s, pqrs_s, qstride_s;
    logic             cfg_bad_s;

    logic [2:0]         p_r, q_r;
    logic [CFG_F_W-1:0] f_r, col_r;
    logic               mode_r, cfg_err_r;
    logic [CNT_W-1:0]   qrs_r, pqrs_r, qstride_r;
    logic [CNT_W-1:0]   wr_ptr_r, psum_ptr_r, mac_k_r, mac_j_r, mac_m_r;

    logic [ELEM_BITS-1:0] filt_spad_r  [FILTER_SPAD_LEN];
    logic [ELEM_BITS-1:0] ifmap_spad_r [IFMAP_SPAD_LEN];
    logic [PSUM_BITS-1:0] psum_spad_r  [PSUM_SPAD_LEN];
    logic [ELEM_BITS-1:0] ifmap_shift_s [IFMAP_SPAD_LEN];

    logic [CNT_W-1:0]     lane_idx_s   [LANES];
    logic                 lane_en_s    [LANES];
    logic [ELEM_BITS-1:0] filt_lane_s  [LANES];
    logic [ELEM_BITS-1:0] ifmap_lane_s [LANES];

    logic filt_fire_s, ifmap_fire_s, ipsum_fire_s, opsum_fire_s;
    logic filt_last_s, ifmap_last_s, psum_last_s, conv_last_s, row_end_s, col_last_s;

    logic [ELEM_BITS-1:0] mac_filt_s, mac_ifmap_s;
    logic [PSUM_BITS-1:0] mac_acc_s, mac_sum_s, out_psum_s;

    // Decode and validate the configuration presented alongside PE_en.
    always_comb begin
        cfg_s     = decode_cfg(i_config);
        qrs_s     = CNT_W'(cfg_s.q) * CNT_W'(cfg_s.rs);
        pqrs_s    = qrs_s * CNT_W'(cfg_s.p);
        qstride_s = CNT_W'(cfg_s.q) * CNT_W'(cfg_s.stride);
        cfg_bad_s = (pqrs_s > CNT_W'(FILTER_SPAD_LEN)) ||
                    (qrs_s > CNT_W'(IFMAP_SPAD_LEN)) ||
                    (CNT_W'(cfg_s.p) > CNT_W'(PSUM_SPAD_LEN)) ||
                    ({1'b0, cfg_s.stride} > cfg_s.rs);
    end

    // Per-lane write addresses, enables and (mode-adjusted) element values.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx_s[l]   = wr_ptr_r + CNT_W'(l);
            lane_en_s[l]    = CNT_W'(l) < CNT_W'(q_r);
            filt_lane_s[l]  = bus.filter[l*ELEM_BITS +: ELEM_BITS];
            ifmap_lane_s[l] = bus.ifmap[l*ELEM_BITS +: ELEM_BITS] ^
                              (mode_r ? SIGN_FLIP : {ELEM_BITS{1'b0}});
        end
    end

    // Ifmap window after sliding by q*stride; vacated tail entries read as zero.
    always_comb begin
        for (int i = 0; i < IFMAP_SPAD_LEN; i++) begin
            ifmap_shift_s[i] = {ELEM_BITS{1'b0}};
            for (int s = 0; s < IFMAP_SPAD_LEN; s++) begin
                ifmap_shift_s[i] = (CNT_W'(s) == CNT_W'(i) + qstride_r) ? ifmap_spad_r[s]
                                                                        : ifmap_shift_s[i];
            end
        end
    end

    assign bus.filter_ready = (state_r == READ_FILTER);
    assign bus.ifmap_ready  = (state_r == READ_IFMAP);
    assign bus.ipsum_ready  = (state_r == READ_IPSUM);
    assign bus.opsum_valid  = (state_r == WRITE_OPSUM);

    assign filt_fire_s  = bus.filter_valid & bus.filter_ready;
    assign ifmap_fire_s = bus.ifmap_valid & bus.ifmap_ready;
    assign ipsum_fire_s = bus.ipsum_valid & bus.ipsum_ready;
    assign opsum_fire_s = bus.opsum_valid & bus.opsum_ready;

    assign filt_last_s  = (wr_ptr_r + CNT_W'(q_r)) >= pqrs_r;
    assign ifmap_last_s = (wr_ptr_r + CNT_W'(q_r)) >= qrs_r;
    assign psum_last_s  = (psum_ptr_r + CNT_ONE) == CNT_W'(p_r);
    assign conv_last_s  = (mac_k_r + CNT_ONE) == pqrs_r;
    assign row_end_s    = (mac_j_r + CNT_ONE) == qrs_r;
    assign col_last_s   = (col_r + 5'd1) == f_r;

    assign mac_filt_s  = filt_spad_r[mac_k_r[FI_IW-1:0]];
    assign mac_ifmap_s = ifmap_spad_r[mac_j_r[IF_IW-1:0]];
    assign mac_acc_s   = psum_spad_r[mac_m_r[PS_IW-1:0]];
    assign out_psum_s  = psum_spad_r[psum_ptr_r[PS_IW-1:0]];

    assign bus.opsum = (state_r == WRITE_OPSUM) ? DATA_BITS'($signed(out_psum_s))
                                                : {DATA_BITS{1'b0}};
    assign done      = opsum_fire_s & psum_last_s & col_last_s;
    assign cfg_err   = cfg_err_r;

    pe_mac #(
        .ELEM_BITS (ELEM_BITS),
        .PSUM_BITS (PSUM_BITS)
    ) u_mac (
        .filt_elem  (mac_filt_s),
        .ifmap_elem (mac_ifmap_s),
        .psum_cur   (mac_acc_s),
        .psum_next  (mac_sum_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (PE_en && !cfg_bad_s) state_s = READ_FILTER;
                else                     state_s = IDLE;
            end
            READ_FILTER: begin
                if (filt_fire_s && filt_last_s) state_s = READ_IFMAP;
                else                            state_s = READ_FILTER;
            end
            READ_IFMAP: begin
                if (ifmap_fire_s && ifmap_last_s) state_s = READ_IPSUM;
                else                              state_s = READ_IFMAP;
            end
            READ_IPSUM: begin
                if (ipsum_fire_s && psum_last_s) state_s = CONV;
                else                             state_s = READ_IPSUM;
            end
            CONV: begin
                if (conv_last_s) state_s = WRITE_OPSUM;
                else             state_s = CONV;
            end
            WRITE_OPSUM: begin
                if (opsum_fire_s && psum_last_s) state_s = col_last_s ? IDLE : READ_IFMAP;
                else                             state_s = WRITE_OPSUM;
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath: config latch, scratchpad writes, MAC sequencing, column stepping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r        <= 3'd0;
            q_r        <= 3'd0;
            f_r        <= {CFG_F_W{1'b0}};
            col_r      <= {CFG_F_W{1'b0}};
            mode_r     <= 1'b0;
            cfg_err_r  <= 1'b0;
            qrs_r      <= {CNT_W{1'b0}};
            pqrs_r     <= {CNT_W{1'b0}};
            qstride_r  <= {CNT_W{1'b0}};
            wr_ptr_r   <= {CNT_W{1'b0}};
            psum_ptr_r <= {CNT_W{1'b0}};
            mac_k_r    <= {CNT_W{1'b0}};
            mac_j_r    <= {CNT_W{1'b0}};
            mac_m_r    <= {CNT_W{1'b0}};
            for (int i = 0; i < FILTER_SPAD_LEN; i++) filt_spad_r[i]  <= {ELEM_BITS{1'b0}};
            for (int i = 0; i < IFMAP_SPAD_LEN; i++)  ifmap_spad_r[i] <= {ELEM_BITS{1'b0}};
            for (int i = 0; i < PSUM_SPAD_LEN; i++)   psum_spad_r[i]  <= {PSUM_BITS{1'b0}};
        end else begin
            cfg_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (PE_en && cfg_bad_s) begin
                        cfg_err_r <= 1'b1;
                    end else if (PE_en) begin
                        p_r        <= cfg_s.p;
                        q_r        <= cfg_s.q;
                        f_r        <= cfg_s.f;
                        mode_r     <= cfg_s.mode;
                        qrs_r      <= qrs_s;
                        pqrs_r     <= pqrs_s;
                        qstride_r  <= qstride_s;
                        wr_ptr_r   <= {CNT_W{1'b0}};
                        psum_ptr_r <= {CNT_W{1'b0}};
                        col_r      <= {CFG_F_W{1'b0}};
                    end
                end
                READ_FILTER: begin
                    if (filt_fire_s) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (lane_en_s[l] && lane_idx_s[l] < CNT_W'(FILTER_SPAD_LEN))
                                filt_spad_r[lane_idx_s[l][FI_IW-1:0]] <= filt_lane_s[l];
                        end
                        wr_ptr_r <= filt_last_s ? {CNT_W{1'b0}} : wr_ptr_r + CNT_W'(q_r);
                    end
                end
                READ_IFMAP: begin
                    if (ifmap_fire_s) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (lane_en_s[l] && lane_idx_s[l] < CNT_W'(IFMAP_SPAD_LEN))
                                ifmap_spad_r[lane_idx_s[l][IF_IW-1:0]] <= ifmap_lane_s[l];
                        end
                        wr_ptr_r <= wr_ptr_r + CNT_W'(q_r);
                    end
                end
                READ_IPSUM: begin
                    if (ipsum_fire_s) begin
                        psum_spad_r[psum_ptr_r[PS_IW-1:0]] <= bus.ipsum[PSUM_BITS-1:0];
                        psum_ptr_r <= psum_last_s ? {CNT_W{1'b0}} : psum_ptr_r + CNT_ONE;
                        mac_k_r    <= {CNT_W{1'b0}};
                        mac_j_r    <= {CNT_W{1'b0}};
                        mac_m_r    <= {CNT_W{1'b0}};
                    end
                end
                CONV: begin
                    psum_spad_r[mac_m_r[PS_IW-1:0]] <= mac_sum_s;
                    mac_k_r <= mac_k_r + CNT_ONE;
                    mac_j_r <= row_end_s ? {CNT_W{1'b0}} : mac_j_r + CNT_ONE;
                    mac_m_r <= row_end_s ? mac_m_r + CNT_ONE : mac_m_r;
                end
                WRITE_OPSUM: begin
                    if (opsum_fire_s && psum_last_s) begin
                        psum_ptr_r <= {CNT_W{1'b0}};
                        col_r      <= col_r + 5'd1;
                        // Later columns only refill the q*stride entries vacated by the slide.
                        wr_ptr_r   <= qrs_r - qstride_r;
                        for (int i = 0; i < IFMAP_SPAD_LEN; i++) ifmap_spad_r[i] <= ifmap_shift_s[i];
                    end else if (opsum_fire_s) begin
                        psum_ptr_r <= psum_ptr_r + CNT_ONE;
                    end
                end
                default: begin
                    cfg_err_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_param.sv
// Directed self-checking bench for pe_param: column sweeps, signed/mode
// arithmetic, output back-pressure, configuration rejection and mid-run reset.
module tb_pe_param;
    import pe_param_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   PE_en;
    logic [CONFIG_SIZE-1:0] i_config;
    logic                   done;
    logic                   cfg_err;
    int checks   = 0;
    int failures = 0;

    pe_param_if #(.DATA_BITS(32)) bus ();

    pe_param dut (
        .clk      (clk),
        .rst      (rst),
        .PE_en    (PE_en),
        .i_config (i_config),
        .bus      (bus.slave),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic logic [CONFIG_SIZE-1:0] make_cfg(input int p, input int q, input int rs,
                                                        input int stride, input int f, input int mode);
        return {1'(stride - 1), 2'(rs - 1), 1'(mode), 2'(p - 1), 5'(f), 2'(q - 1)};
    endfunction

    // All drivers below are entered at posedge+1 and return at posedge+1.
    task automatic start(input logic [CONFIG_SIZE-1:0] c);
        PE_en = 1'b1;
        i_config = c;
        @(posedge clk); #1;
        PE_en = 1'b0;
    endtask

    task automatic push(input int which, input logic [31:0] d);
        logic rdy;
        bit   ok = 1'b0;
        case (which)
            0: begin bus.filter = d; bus.filter_valid = 1'b1; end
            1: begin bus.ifmap  = d; bus.ifmap_valid  = 1'b1; end
            default: begin bus.ipsum = d; bus.ipsum_valid = 1'b1; end
        endcase
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            case (which)
                0: rdy = bus.filter_ready;
                1: rdy = bus.ifmap_ready;
                default: rdy = bus.ipsum_ready;
            endcase
            if (rdy) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin @(posedge clk); #1; end
        bus.filter_valid = 1'b0;
        bus.ifmap_valid  = 1'b0;
        bus.ipsum_valid  = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL push_timeout: channel %0d ready got 0 expected 1", which);
        end
    endtask

    task automatic pop(output logic [31:0] d, output logic dn);
        bit ok = 1'b0;
        d  = 32'hxxxx_xxxx;
        dn = 1'bx;
        bus.opsum_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.opsum_valid) begin
                d  = bus.opsum;
                dn = done;
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin @(posedge clk); #1; end
        bus.opsum_ready = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL pop_timeout: opsum_valid got 0 expected 1");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready, bus.opsum_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_readies: got %b expected 0000",
                     {bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready, bus.opsum_valid});
        end
        checks++;
        if ({bus.opsum, done, cfg_err} !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs: opsum %h done %b cfg_err %b expected all 0",
                     bus.opsum, done, cfg_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic        dn;
        start(make_cfg(1, 1, 3, 1, 2, 0));
        @(negedge clk);
        checks++;
        if (bus.filter_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_filter_ready: got %b expected 1", bus.filter_ready);
        end
        @(posedge clk); #1;
        push(0, 32'd1); push(0, 32'd2); push(0, 32'd3);
        push(1, 32'd1); push(1, 32'd2); push(1, 32'd3);
        push(2, 32'd0);
        pop(d, dn);
        checks++;
        if (d !== 32'd14 || dn !== 1'b0) begin
            failures++;
            $display("FAIL basic_col0: opsum %0d done %b expected 14 done 0", d, dn);
        end
        push(1, 32'd4);
        push(2, 32'd0);
        pop(d, dn);
        checks++;
        if (d !== 32'd20 || dn !== 1'b1) begin
            failures++;
            $display("FAIL basic_col1: opsum %0d done %b expected 20 done 1", d, dn);
        end
        @(negedge clk);
        checks++;
        if (bus.filter_ready !== 1'b0 || bus.ifmap_ready !== 1'b0 || bus.opsum_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle: filter_ready %b ifmap_ready %b opsum_valid %b expected 0 0 0",
                     bus.filter_ready, bus.ifmap_ready, bus.opsum_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mode();
        logic [31:0] d;
        logic        dn;
        // F field 0 behaves as a single column.
        start(make_cfg(1, 1, 1, 1, 0, 1));
        push(0, 32'h0000_0002);
        push(1, 32'h0000_0081);
        push(2, 32'd5);
        pop(d, dn);
        checks++;
        if (d !== 32'd7 || dn !== 1'b1) begin
            failures++;
            $display("FAIL mode_unsigned: opsum %0d done %b expected 7 done 1", d, dn);
        end
    endtask

    task automatic test_signed();
        logic [31:0] d;
        logic        dn;
        // (-1)*(-128) added to -1 wraps through zero to 127.
        start(make_cfg(1, 1, 1, 1, 1, 0));
        push(0, 32'h0000_00FF);
        push(1, 32'h0000_0080);
        push(2, 32'hFFFF_FFFF);
        pop(d, dn);
        checks++;
        if (d !== 32'h0000_007F || dn !== 1'b1) begin
            failures++;
            $display("FAIL signed_wrap: opsum %h done %b expected 0000007f done 1", d, dn);
        end
    endtask

    task automatic test_multi();
        logic [31:0] d;
        logic        dn;
        logic [31:0] exp_sum [4];
        logic        exp_dn  [4];
        exp_sum = '{32'd10, 32'd10, 32'd26, 32'd26};
        exp_dn  = '{1'b0, 1'b0, 1'b0, 1'b1};
        start(make_cfg(2, 2, 2, 2, 2, 0));
        for (int i = 0; i < 4; i++) push(0, 32'hFFFF_0101);
        push(1, 32'hAABB_0201);
        push(1, 32'hCCDD_0403);
        for (int c = 0; c < 2; c++) begin
            if (c == 1) begin
                push(1, 32'h1122_0605);
                push(1, 32'h3344_0807);
            end
            push(2, 32'd0);
            push(2, 32'd0);
            for (int k = 0; k < 2; k++) begin
                pop(d, dn);
                checks++;
                if (d !== exp_sum[c*2+k] || dn !== exp_dn[c*2+k]) begin
                    failures++;
                    $display("FAIL multi_out%0d: opsum %0d done %b expected %0d done %b",
                             c*2+k, d, dn, exp_sum[c*2+k], exp_dn[c*2+k]);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] d;
        logic        dn;
        bit          seen = 1'b0;
        start(make_cfg(1, 1, 1, 1, 1, 0));
        push(0, 32'd3);
        push(1, 32'd4);
        push(2, 32'd1);
        bus.opsum_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.opsum_valid) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL stall_valid: opsum_valid got 0 expected 1");
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.opsum !== 32'd13 || bus.opsum_valid !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: opsum %0d valid %b done %b expected 13 1 0",
                         i, bus.opsum, bus.opsum_valid, done);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        pop(d, dn);
        checks++;
        if (d !== 32'd13 || dn !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: opsum %0d done %b expected 13 done 1", d, dn);
        end
        @(negedge clk);
        checks++;
        if (bus.opsum_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_extra: opsum_valid got %b expected 0", bus.opsum_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cfg_err();
        start(make_cfg(1, 1, 1, 2, 1, 0));
        @(negedge clk);
        checks++;
        if (cfg_err !== 1'b1 || bus.filter_ready !== 1'b0) begin
            failures++;
            $display("FAIL cfg_err_pulse: cfg_err %b filter_ready %b expected 1 0",
                     cfg_err, bus.filter_ready);
        end
        @(negedge clk);
        checks++;
        if (cfg_err !== 1'b0 || bus.filter_ready !== 1'b0) begin
            failures++;
            $display("FAIL cfg_err_after: cfg_err %b filter_ready %b expected 0 0",
                     cfg_err, bus.filter_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid();
        bit seen = 1'b0;
        start(make_cfg(1, 4, 4, 1, 1, 0));
        for (int i = 0; i < 4; i++) push(0, 32'h0101_0101);
        for (int i = 0; i < 4; i++) push(1, 32'h0101_0101);
        push(2, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready, bus.opsum_valid, done, cfg_err} !== 6'd0
            || bus.opsum !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs: readies/valid/done/err %b opsum %h expected all 0",
                     {bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready, bus.opsum_valid, done, cfg_err},
                     bus.opsum);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.opsum_valid || bus.filter_ready) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rst_mid_idle: activity after reset got 1 expected 0");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        PE_en = 1'b0;
        i_config = '0;
        bus.filter = 32'd0; bus.filter_valid = 1'b0;
        bus.ifmap  = 32'd0; bus.ifmap_valid  = 1'b0;
        bus.ipsum  = 32'd0; bus.ipsum_valid  = 1'b0;
        bus.opsum_ready = 1'b0;
        test_reset();
        test_basic();
        test_mode();
        test_signed();
        test_multi();
        test_back_pressure();
        test_cfg_err();
        test_rst_mid();
        test_signed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
